// File: rtl/motoro3_pkg.sv
// Shared state encoding and step constants for the motoro3 commutation sequencer.
package motoro3_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ARM,
    SEQ_RUN,
    SEQ_STOPPING
  } seq_state_e;

  localparam logic [3:0] STEP_MAX   = 4'd11;
  localparam logic [3:0] HALF_FWD_A = 4'd5;
  localparam logic [3:0] HALF_FWD_B = 4'd11;
  localparam logic [3:0] HALF_REV_A = 4'd6;
  localparam logic [3:0] HALF_REV_B = 4'd0;
  localparam int         MIN_STEP_LEN = 4;

  // True when the step closes a half electrical cycle in the given direction.
  function automatic logic is_half_last(input logic [3:0] step, input logic rev);
    return rev ? ((step == HALF_REV_A) || (step == HALF_REV_B))
               : ((step == HALF_FWD_A) || (step == HALF_FWD_B));
  endfunction

endpackage

// File: rtl/motoro3_step_counter.sv
// Wrapping 0..11 electrical step counter with synchronous clear, enable and direction.
module motoro3_step_counter
  import motoro3_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       clr,
  input  logic       en,
  input  logic       rev,
  output logic [3:0] step
);

  logic [3:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (clr) begin
      step_d = 4'd0;
    end else if (en) begin
      if (rev) step_d = (step_q == 4'd0) ? STEP_MAX : step_q - 4'd1;
      else     step_d = (step_q == STEP_MAX) ? 4'd0 : step_q + 4'd1;
    end
  end

  // Falling-edge update keeps this aligned with the PWM datapath.
  always_ff @(negedge clk) begin
    if (!nRst) step_q <= 4'd0;
    else       step_q <= step_d;
  end

  assign step = step_q;

endmodule

// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation scheduler feeding motoro3_pwm_generator.
// Build option M3SEQ_STOP_AT_HALF_EN: a stop request only completes at a half-cycle step end.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int CNT_W = 25,
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             stop,
  input  logic             dirRev,
  input  logic [CNT_W-1:0] m3r_stepLen,
  output logic [3:0]       sgStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst2,
  output logic             m3cntFirst1,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic             pwmActive1,
  output logic             pwmLastStep1,
  output logic             stepTick,
  output logic             cycleDone,
  output logic [REV_W-1:0] revCnt
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             dir_q, dir_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic [CNT_W-1:0] len_samp;
  logic             step_en, step_clr, step_dir;
  logic             active, last1, half_last, stop_boundary, cycle_end;

  motoro3_step_counter u_step (
    .clk  (clk),
    .nRst (nRst),
    .clr  (step_clr),
    .en   (step_en),
    .rev  (step_dir),
    .step (sgStep)
  );

  // Clamping to four clocks keeps First2/First1/Last2/Last1 on distinct clocks.
  assign len_samp  = (m3r_stepLen < CNT_W'(MIN_STEP_LEN)) ? CNT_W'(MIN_STEP_LEN) : m3r_stepLen;
  assign active    = (state_q == SEQ_RUN) || (state_q == SEQ_STOPPING);
  assign last1     = active && (cnt_q == '0);
  assign half_last = is_half_last(sgStep, dir_q);
  assign cycle_end = last1 && (sgStep == (dir_q ? 4'd0 : STEP_MAX));

`ifdef M3SEQ_STOP_AT_HALF_EN
  assign stop_boundary = half_last;
`else
  assign stop_boundary = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    dir_d    = dir_q;
    rev_d    = cycle_end ? rev_q + REV_W'(1) : rev_q;
    step_en  = 1'b0;
    step_clr = 1'b0;
    step_dir = dir_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start && !stop) state_d = SEQ_ARM;
      end
      SEQ_ARM: begin
        if (stop) begin
          state_d = SEQ_IDLE;
        end else begin
          state_d  = SEQ_RUN;
          len_d    = len_samp;
          dir_d    = dirRev;
          cnt_d    = len_samp - CNT_W'(1);
          step_clr = 1'b1;
        end
      end
      SEQ_RUN, SEQ_STOPPING: begin
        if ((state_q == SEQ_RUN) && stop) state_d = SEQ_STOPPING;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((state_q == SEQ_STOPPING) && stop_boundary) begin
          state_d = SEQ_IDLE;
          cnt_d   = '0;
        end else begin
          // Step boundary: new length/direction apply to the step being entered.
          len_d    = len_samp;
          dir_d    = dirRev;
          cnt_d    = len_samp - CNT_W'(1);
          step_en  = 1'b1;
          step_dir = dirRev;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!nRst) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      len_q   <= CNT_W'(MIN_STEP_LEN);
      dir_q   <= 1'b0;
      rev_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      rev_q   <= rev_d;
    end
  end

  assign m3cnt        = cnt_q;
  assign pwmActive1   = active;
  assign m3cntFirst2  = active && (cnt_q == len_q - CNT_W'(1));
  assign m3cntFirst1  = active && (cnt_q == len_q - CNT_W'(2));
  assign m3cntLast2   = active && (cnt_q == CNT_W'(1));
  assign m3cntLast1   = last1;
  assign stepTick     = last1;
  assign pwmLastStep1 = active && half_last;
  assign cycleDone    = cycle_end;
  assign revCnt       = rev_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Bench for motoro3_step_sequencer: directed scenarios plus randomized traffic against a step/position model.
module tb_motoro3_step_sequencer;

  localparam int CNT_W = 25;
  localparam int REV_W = 16;
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_STOP = 3;

  logic             clk = 1'b0;
  logic             nRst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             dirRev = 1'b0;
  logic [CNT_W-1:0] m3r_stepLen = CNT_W'(10);
  logic [3:0]       sgStep;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
  logic             pwmActive1, pwmLastStep1, stepTick, cycleDone;
  logic [REV_W-1:0] revCnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: phase, step index, clock position inside the step, latched length/direction.
  int          ph = P_IDLE;
  int          m_step = 0, m_pos = 0, m_len = 4;
  bit          m_dir = 1'b0;
  logic [15:0] m_rev = 16'd0;
  bit          m_eos;

  motoro3_step_sequencer #(.CNT_W(CNT_W), .REV_W(REV_W)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .start        (start),
    .stop         (stop),
    .dirRev       (dirRev),
    .m3r_stepLen  (m3r_stepLen),
    .sgStep       (sgStep),
    .m3cnt        (m3cnt),
    .m3cntFirst2  (m3cntFirst2),
    .m3cntFirst1  (m3cntFirst1),
    .m3cntLast2   (m3cntLast2),
    .m3cntLast1   (m3cntLast1),
    .pwmActive1   (pwmActive1),
    .pwmLastStep1 (pwmLastStep1),
    .stepTick     (stepTick),
    .cycleDone    (cycleDone),
    .revCnt       (revCnt)
  );

  always #50 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input logic [CNT_W-1:0] l);
    return (l < 4) ? 4 : int'(l);
  endfunction

  function automatic bit half_step(input int s, input bit rev);
    return rev ? (s == 6 || s == 0) : (s == 5 || s == 11);
  endfunction

  function automatic bit stop_here(input int s, input bit rev);
`ifdef M3SEQ_STOP_AT_HALF_EN
    return half_step(s, rev);
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (!nRst) begin
      ph = P_IDLE; m_step = 0; m_pos = 0; m_len = 4; m_dir = 1'b0; m_rev = 16'd0;
    end else begin
      case (ph)
        P_IDLE: if (start && !stop) ph = P_ARM;
        P_ARM: begin
          if (stop) ph = P_IDLE;
          else begin
            m_len = clamp_len(m3r_stepLen); m_dir = dirRev; m_step = 0; m_pos = 0; ph = P_RUN;
          end
        end
        default: begin
          m_eos = (m_pos == m_len - 1);
          if (m_eos && m_step == (m_dir ? 0 : 11)) m_rev = m_rev + 16'd1;
          if (!m_eos) begin
            m_pos++;
            if (ph == P_RUN && stop) ph = P_STOP;
          end else if (ph == P_STOP && stop_here(m_step, m_dir)) begin
            ph = P_IDLE; m_pos = 0;
          end else begin
            if (ph == P_RUN && stop) ph = P_STOP;
            m_len  = clamp_len(m3r_stepLen);
            m_dir  = dirRev;
            m_step = (m_step + (m_dir ? 11 : 1)) % 12;
            m_pos  = 0;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      bit act;
      act = (ph == P_RUN) || (ph == P_STOP);
      chk("sgStep", sgStep, m_step);
      chk("m3cnt", m3cnt, act ? (m_len - 1 - m_pos) : 0);
      chk("m3cntFirst2", m3cntFirst2, act && m_pos == 0);
      chk("m3cntFirst1", m3cntFirst1, act && m_pos == 1);
      chk("m3cntLast2", m3cntLast2, act && m_pos == m_len - 2);
      chk("m3cntLast1", m3cntLast1, act && m_pos == m_len - 1);
      chk("stepTick", stepTick, act && m_pos == m_len - 1);
      chk("pwmActive1", pwmActive1, act);
      chk("pwmLastStep1", pwmLastStep1, act && half_step(m_step, m_dir));
      chk("cycleDone", cycleDone, act && m_pos == m_len - 1 && m_step == (m_dir ? 0 : 11));
      chk("revCnt", revCnt, m_rev);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Leaves the bench at the posedge where the sequencer shows its first RUN clock.
  task automatic start_run(input int len, input bit rev);
    @(posedge clk);
    m3r_stepLen = CNT_W'(len); dirRev = rev; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    @(posedge clk);
  endtask

  task automatic stop_and_wait(input int max_cycles);
    int n;
    stop = 1'b1;
    @(posedge clk);
    stop = 1'b0;
    n = 0;
    while (pwmActive1 !== 1'b0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    chk("wait_idle_pwmActive1", pwmActive1, 0);
  endtask

  initial begin
    int stop_k, r;
    tick(2);
    chk_en = 1'b1;
    chk("rst_m3cnt", m3cnt, 0);
    chk("rst_sgStep", sgStep, 0);
    chk("rst_pwmActive1", pwmActive1, 0);
    chk("rst_revCnt", revCnt, 0);
    nRst = 1'b1;

    // Forward run, 10 clocks per step.
    start_run(10, 1'b0);
    chk("run_active", pwmActive1, 1);
    chk("run_first2", m3cntFirst2, 1);
    chk("run_m3cnt0", m3cnt, 9);
    tick(1);  chk("k1_first1", m3cntFirst1, 1);
    tick(7);  chk("k8_last2", m3cntLast2, 1);
    tick(1);  chk("k9_last1", m3cntLast1, 1);
    tick(1);  chk("k10_step", sgStep, 1);
    tick(109); chk("k119_cycleDone", cycleDone, 1); chk("k119_step", sgStep, 11);
    tick(1);  chk("k120_revCnt", revCnt, 1); chk("k120_step", sgStep, 0);

    // Length change in the middle of step 3 of the second cycle.
    tick(35); m3r_stepLen = CNT_W'(20);
    tick(4);  chk("k159_tick", stepTick, 1); chk("k159_step", sgStep, 3);
    tick(1);  chk("k160_step", sgStep, 4); chk("k160_m3cnt", m3cnt, 19);
    tick(18); chk("k178_tick", stepTick, 0);
    tick(1);  chk("k179_tick", stepTick, 1);
    tick(1);  chk("k180_step", sgStep, 5);

    // Reset during step 7.
    tick(45); chk("k225_step", sgStep, 7);
    nRst = 1'b0;
    tick(1);
    chk("midrst_m3cnt", m3cnt, 0);
    chk("midrst_step", sgStep, 0);
    chk("midrst_active", pwmActive1, 0);
    chk("midrst_revCnt", revCnt, 0);
    nRst = 1'b1;

    // Stop requested in step 2.
`ifdef M3SEQ_STOP_AT_HALF_EN
    stop_k = 60;
`else
    stop_k = 30;
`endif
    start_run(10, 1'b0);
    chk("restart_step", sgStep, 0);
    tick(25); stop = 1'b1;
    tick(1);  stop = 1'b0;
    tick(stop_k - 27);
    chk("stop_last_active", pwmActive1, 1);
    chk("stop_last_step", sgStep, (stop_k == 60) ? 5 : 2);
    tick(1);
    chk("stop_exit_active", pwmActive1, 0);
    chk("stop_exit_m3cnt", m3cnt, 0);

    // Length 2 is clamped to 4.
    start_run(2, 1'b0);
    chk("clamp_m3cnt", m3cnt, 3);
    chk("clamp_first2", m3cntFirst2, 1); chk("clamp_k0_first1", m3cntFirst1, 0);
    tick(1); chk("clamp_first1", m3cntFirst1, 1); chk("clamp_k1_last2", m3cntLast2, 0);
    tick(1); chk("clamp_last2", m3cntLast2, 1); chk("clamp_k2_last1", m3cntLast1, 0);
    tick(1); chk("clamp_last1", m3cntLast1, 1);
    tick(1); chk("clamp_step1", sgStep, 1); chk("clamp_k4_first2", m3cntFirst2, 1);
    stop_and_wait(200);

    // Reverse run.
    start_run(10, 1'b1);
    chk("rev_k0_half", pwmLastStep1, 1);
    tick(9);  chk("rev_k9_cycleDone", cycleDone, 1);
    tick(1);  chk("rev_k10_step", sgStep, 11); chk("rev_k10_revCnt", revCnt, 1);
    chk("rev_k10_half", pwmLastStep1, 0);
    tick(50); chk("rev_k60_step", sgStep, 6); chk("rev_k60_half", pwmLastStep1, 1);
    stop_and_wait(300);

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      r = $urandom_range(0, 199);
      nRst  = (r != 199);
      start = (r < 12);
      stop  = (r >= 10 && r < 15);
      if (r >= 20 && r < 26) m3r_stepLen = CNT_W'($urandom_range(0, 15));
      if (ph == P_IDLE && !start && r >= 30 && r < 40) dirRev = $urandom_range(0, 1);
    end
    start = 1'b0; stop = 1'b0; nRst = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
# motoro3_step_sequencer

Commutation scheduler for the 3-phase motor PWM datapath. Generates the 12-step electrical sequence `sgStep`, the per-step down-counter `m3cnt` with its first/last strobes, and `pwmActive1`/`pwmLastStep1`. These are exactly the control inputs consumed by `motoro3_pwm_generator`. Also handles start/stop, direction, per-step length latching and electrical-cycle counting.

## Interface
- `CNT_W`, 25, width of `m3cnt` and of the step length.
- `REV_W`, 16, width of the electrical-cycle counter.
- `clk`  in  1  system clock (10 MHz). All registers update on the falling edge, matching the PWM datapath.
- `nRst`  in  1  reset. One clock; reset is synchronous and active-low.
- `start`  in  1  run request, level-sampled.
- `stop`  in  1  stop request, level-sampled.
- `dirRev`  in  1  0 = forward, 1 = reverse. Sampled at step boundaries.
- `m3r_stepLen`  in  CNT_W  clocks per step. Sampled at step boundaries.
- `sgStep`  out  4  current step, 0..11.
- `m3cnt`  out  CNT_W  remaining clocks in the step. Counts down to 0.
- `m3cntFirst2`, `m3cntFirst1`  out  1  first and second clock of a step.
- `m3cntLast2`, `m3cntLast1`  out  1  second-to-last and last clock of a step.
- `pwmActive1`  out  1  sequencer in RUN or STOPPING.
- `pwmLastStep1`  out  1  active and step is last of a half-cycle.
- `stepTick`  out  1  pulse on the last clock of every step.
- `cycleDone`  out  1  pulse on the last clock of a full 12-step cycle.
- `revCnt`  out  REV_W  completed electrical cycles. Wraps.

## Operation
- States: IDLE, ARM, RUN, STOPPING.
- IDLE:
  - `start`=1 and `stop`=0 → ARM.
  - `stop` has priority when both are asserted.
- ARM (one clock):
  - Latch `lenSh` = max(`m3r_stepLen`, 4) and `dirSh` = `dirRev`.
  - Next edge → RUN with `sgStep`=0 and `m3cnt`=`lenSh`-1.
- RUN:
  - `m3cnt` decrements by 1 each clock.
  - When `m3cnt`=0 (step end):
    - Re-latch `lenSh`/`dirSh`.
    - Reload `m3cnt`=`lenSh`-1.
    - Advance `sgStep`: forward 11→0 wrap; reverse 0→11 wrap.
  - `stop`=1 → STOPPING. `start` is ignored.
- STOPPING: counts like RUN. At the stop boundary → IDLE. The boundary is defined under Configuration.
- Strobe decode, combinational from registered state and `m3cnt`, gated by RUN/STOPPING:
  - `m3cntFirst2` when `m3cnt`=`lenSh`-1.
  - `m3cntFirst1` when `m3cnt`=`lenSh`-2.
  - `m3cntLast2` when `m3cnt`=1.
  - `m3cntLast1` when `m3cnt`=0.
  - `stepTick` = `m3cntLast1`.
- `pwmLastStep1`: active and `sgStep` is 5 or 11 (forward) or 6 or 0 (reverse).
- `cycleDone`: `stepTick` on step 11 (forward) or step 0 (reverse). `revCnt` increments on the same edge and wraps at 2^REV_W.
- `lenSh` is clamped to a minimum of 4, so the four strobes never overlap.

## Timing
- Reset values, applied on any edge with `nRst`=0 including mid-run:
  - state IDLE; `sgStep`=0, `m3cnt`=0, `revCnt`=0, `lenSh`=4, `dirSh`=0.
  - All strobes, `pwmActive1`, `pwmLastStep1`, `stepTick` and `cycleDone` are 0.
- `start` seen at edge N → ARM at N+1 → RUN at N+2. At N+2, `pwmActive1`=1 and `m3cntFirst2`=1.
- A step lasts exactly `lenSh` clocks, so a full cycle is 12 × `lenSh` clocks when the length is held constant.
- A length or direction change takes effect on the step after the boundary where it is sampled, never mid-step.
- Exit to IDLE: the edge after the final `m3cntLast1`. `pwmActive1` falls on that edge and `m3cnt` returns to 0.
- `stop` asserted in ARM → IDLE on the next edge, with no active cycle.

## Configuration
- `M3SEQ_STOP_AT_HALF_EN` defined: STOPPING ends only at a `pwmLastStep1` step end. That is the end of step 5/11 forward or step 6/0 reverse, so the PWM accumulators close on a half-cycle.
- Undefined: STOPPING ends at the end of the current step.

## Structure
- Shared package `motoro3_pkg` holds:
  - state encoding;
  - step constants (STEP_MAX=11, half-cycle last steps 5/11/6/0);
  - minimum length 4.
- One natural sub-module, `motoro3_step_counter`: wrapping up/down 0..11 counter with enable and direction. The FSM, length shadow and strobe decode stay in the top module.

## Test plan
- Reset, `m3r_stepLen`=10, `start` pulse:
  - RUN two edges later;
  - `sgStep` sequence 0,1,…,11,0;
  - each step 10 clocks;
  - strobes at `m3cnt` 9/8/1/0;
  - `cycleDone` and `revCnt`=1 after 120 clocks.
- `m3r_stepLen`=2: clamped to 4. All four strobes are distinct, one clock each.
- `dirRev`=1 at start: sequence 0,11,10,…; `pwmLastStep1` high on steps 0 and 6; `cycleDone` at the end of step 0.
- Change `m3r_stepLen` 10→20 in mid-step 3: step 3 still lasts 10 clocks and step 4 lasts 20.
- `stop` in step 2:
  - with `M3SEQ_STOP_AT_HALF_EN`, IDLE after step 5 ends;
  - without it, IDLE after step 2 ends;
  - `pwmActive1` falls on that edge.
- `nRst`=0 during step 7: all outputs return to reset values on the next edge; `start` then restarts at step 0.
